// File: rtl/io_controller.sv
// I/O port responder: bridges core word reads and byte writes to UART rx/tx byte engines
// through an RX FIFO and a TX FIFO. Each FIFO has its own count, so full and empty are distinct.
module io_controller #(
    parameter int RX_AW = 10,
    parameter int TX_AW = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        input_req,
    output logic [31:0] input_data,
    output logic        input_valid,
    input  logic [31:0] output_data,
    input  logic        output_valid,
    output logic        io_stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        rx_overrun,
    output logic        tx_overrun
);

    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;

    typedef enum logic [1:0] {IDLE, COLLECT, RESP} in_state_t;
    typedef enum logic {T_IDLE, T_GUARD} tx_state_t;

    in_state_t in_state, in_state_next;
    tx_state_t tx_state, tx_state_next;

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count, rx_count_next;
    logic           rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]     rx_head;

    // Handshakes are pulse based, with no back-pressure except io_stall: a push is
    // accepted when the FIFO has room, or when a pop in the same cycle frees a slot.
    assign rx_full  = rx_count[RX_AW];
    assign rx_empty = (rx_count == '0);
    assign rx_head  = rx_mem[rx_rd_ptr];
    assign rx_pop   = (in_state == COLLECT) && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);

    always_comb begin
        rx_count_next = rx_count;
        if (rx_push && !rx_pop)
            rx_count_next = rx_count + 1'b1;
        else if (!rx_push && rx_pop)
            rx_count_next = rx_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count_next;
            if (rx_valid && !rx_push)
                rx_overrun <= 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count, tx_count_next;
    logic           tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]     tx_head, tx_data_q;
    logic           unused_out_hi;

    assign unused_out_hi = &{1'b0, output_data[31:8]};
    assign tx_full  = tx_count[TX_AW];
    assign tx_empty = (tx_count == '0);
    assign tx_head  = tx_mem[tx_rd_ptr];
    assign tx_pop   = tx_start;
    assign tx_push  = output_valid && (!tx_full || tx_pop);

    always_comb begin
        tx_count_next = tx_count;
        if (tx_push && !tx_pop)
            tx_count_next = tx_count + 1'b1;
        else if (!tx_push && tx_pop)
            tx_count_next = tx_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= output_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            tx_count   <= '0;
            tx_overrun <= 1'b0;
            io_stall   <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count_next;
            // Registered from the next count so stall rises together with full.
            io_stall <= tx_count_next[TX_AW];
            if (output_valid && !tx_push)
                tx_overrun <= 1'b1;
        end
    end

    // ---------------- Input FSM ----------------
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;

    always_ff @(posedge clk) begin
        if (!rstn)
            in_state <= IDLE;
        else
            in_state <= in_state_next;
    end

    always_comb begin
        in_state_next = in_state;
        input_valid   = 1'b0;
        case (in_state)
            IDLE:    if (input_req) in_state_next = COLLECT;
            COLLECT: if (rx_pop && byte_idx == 2'd3) in_state_next = RESP;
            RESP: begin
                input_valid   = 1'b1;
                in_state_next = IDLE;
            end
            default: in_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_idx   <= 2'd0;
            word_lo    <= '0;
            input_data <= '0;
        end else begin
            if (in_state == IDLE)
                byte_idx <= 2'd0;
            if (rx_pop) begin
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0:    word_lo[7:0]   <= rx_head;
                    2'd1:    word_lo[15:8]  <= rx_head;
                    2'd2:    word_lo[23:16] <= rx_head;
                    default: input_data     <= {rx_head, word_lo};
                endcase
            end
        end
    end

    // ---------------- TX FSM ----------------
    // T_GUARD spends one cycle after each start because tx_busy lags tx_start by a cycle.
    always_ff @(posedge clk) begin
        if (!rstn)
            tx_state <= T_IDLE;
        else
            tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_start      = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_start      = 1'b1;
                    tx_state_next = T_GUARD;
                end
            end
            T_GUARD: tx_state_next = T_IDLE;
            default: tx_state_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            tx_data_q <= '0;
        else if (tx_start)
            tx_data_q <= tx_head;
    end

    // The head byte is presented during the start cycle and held afterwards.
    assign tx_data = tx_start ? tx_head : tx_data_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: byte scoreboards for the RX word path and the TX byte path,
// with latency, stall, overrun, wrap and issue-rate checks.
module tb_io_controller;

    logic        clk;
    logic        rstn;
    logic        input_req;
    logic [31:0] input_data;
    logic        input_valid;
    logic [31:0] output_data;
    logic        output_valid;
    logic        io_stall;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        rx_overrun;
    logic        tx_overrun;

    io_controller dut (
        .clk          (clk),
        .rstn         (rstn),
        .input_req    (input_req),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .output_data  (output_data),
        .output_valid (output_valid),
        .io_stall     (io_stall),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .rx_overrun   (rx_overrun),
        .tx_overrun   (tx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int iv_cnt = 0;
    int iv_cyc = 0;
    int ts_cnt = 0;
    int ts_cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Output monitor for the cycle in progress; runs at the falling edge.
    task automatic sample();
        logic [31:0] w;
        if (!mon_en) return;
        if (input_valid) begin
            iv_cnt++;
            iv_cyc = cyc;
            if (rx_exp_q.size() >= 4) begin
                w[7:0]   = rx_exp_q.pop_front();
                w[15:8]  = rx_exp_q.pop_front();
                w[23:16] = rx_exp_q.pop_front();
                w[31:24] = rx_exp_q.pop_front();
                check("input_data", input_data, w);
            end else begin
                check("input_valid_unexpected", 32'(input_valid), 32'd0);
            end
        end
        if (tx_start) begin
            ts_cnt++;
            ts_cyc = cyc;
            if (tx_exp_q.size() > 0)
                check("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
            else
                check("tx_start_unexpected", 32'(tx_start), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_exp_q.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [31:0] d);
        output_valid = 1'b1;
        output_data  = d;
        tx_exp_q.push_back(d[7:0]);
        tick();
        output_valid = 1'b0;
    endtask

    task automatic pulse_req();
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
    endtask

    task automatic wait_iv(input int budget);
        int start;
        int n;
        start = iv_cnt;
        n = 0;
        while (iv_cnt == start && n < budget) begin
            tick();
            n++;
        end
        check("input_valid_timeout", 32'(iv_cnt != start), 32'd1);
    endtask

    task automatic wait_ts(input int budget);
        int start;
        int n;
        start = ts_cnt;
        n = 0;
        while (ts_cnt == start && n < budget) begin
            tick();
            n++;
        end
        check("tx_start_timeout", 32'(ts_cnt != start), 32'd1);
    endtask

    initial begin
        int c0;
        int s;
        int n;
        logic [7:0] t3 [4];

        t3[0] = 8'hA1; t3[1] = 8'hB2; t3[2] = 8'hC3; t3[3] = 8'hD4;

        // Reset with junk on every input.
        rstn = 1'b0;
        input_req = 1'b1;
        output_data = 32'hFFFF_FFFF;
        output_valid = 1'b1;
        rx_data = 8'hEE;
        rx_valid = 1'b1;
        tx_busy = 1'b0;
        tick();
        tick();
        check("rst_input_data", input_data, 32'd0);
        check("rst_input_valid", 32'(input_valid), 32'd0);
        check("rst_io_stall", 32'(io_stall), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        check("rst_tx_overrun", 32'(tx_overrun), 32'd0);
        check("rst_rx_count", 32'(dut.rx_count), 32'd0);
        check("rst_tx_count", 32'(dut.tx_count), 32'd0);
        input_req = 1'b0;
        output_valid = 1'b0;
        output_data = '0;
        rx_valid = 1'b0;
        rx_data = '0;
        rstn = 1'b1;
        mon_en = 1'b1;
        tick();

        // Buffered word: response five cycles after the request, one cycle wide.
        push_rx(8'h78);
        push_rx(8'h56);
        push_rx(8'h34);
        push_rx(8'h12);
        c0 = cyc;
        s = iv_cnt;
        pulse_req();
        wait_iv(10);
        check("resp_latency", 32'(iv_cyc - c0), 32'd5);
        repeat (5) tick();
        check("resp_pulse_count", 32'(iv_cnt - s), 32'd1);
        check("input_data_hold", input_data, 32'h1234_5678);

        // Request with RX empty; slow bytes; a second request mid-collect is ignored.
        s = iv_cnt;
        pulse_req();
        for (int i = 0; i < 4; i++) begin
            repeat (19) tick();
            if (i == 2)
                pulse_req();
            if (i == 3)
                check("no_early_resp", 32'(iv_cnt - s), 32'd0);
            push_rx(t3[i]);
        end
        wait_iv(10);
        check("slow_word", input_data, 32'hD4C3_B2A1);
        repeat (20) tick();
        check("second_req_ignored", 32'(iv_cnt - s), 32'd1);

        // TX: start one cycle after the push; held off while busy.
        tx_busy = 1'b0;
        c0 = cyc;
        push_tx(32'hDEAD_BE41);
        wait_ts(10);
        check("tx_start_latency", 32'(ts_cyc - c0), 32'd1);
        tx_busy = 1'b1;
        s = ts_cnt;
        push_tx(32'h1234_5699);
        repeat (100) tick();
        check("tx_held_by_busy", 32'(ts_cnt - s), 32'd0);
        c0 = cyc;
        tx_busy = 1'b0;
        wait_ts(10);
        check("tx_restart", 32'(ts_cyc - c0), 32'd0);
        tx_busy = 1'b1;

        // Fill TX, stall, overrun, then drain at full rate.
        for (int i = 0; i < 1024; i++) begin
            push_tx({24'($urandom), 8'($urandom_range(0, 255))});
            if (i == 1022)
                check("stall_below_full", 32'(io_stall), 32'd0);
        end
        check("stall_full", 32'(io_stall), 32'd1);
        check("tx_count_full", 32'(dut.tx_count), 32'd1024);
        check("tx_overrun_clear", 32'(tx_overrun), 32'd0);
        output_valid = 1'b1;
        output_data = 32'h0000_00AB;
        tick();
        output_valid = 1'b0;
        check("tx_overrun_set", 32'(tx_overrun), 32'd1);
        check("tx_count_after_drop", 32'(dut.tx_count), 32'd1024);
        tx_busy = 1'b0;
        n = 0;
        while (tx_exp_q.size() > 0 && n < 5000) begin
            tick();
            n++;
        end
        check("tx_drain_cycles", 32'(n), 32'd2047);
        check("tx_count_drained", 32'(dut.tx_count), 32'd0);
        check("stall_drained", 32'(io_stall), 32'd0);

        // Fill RX, overrun, push+pop while full, then drain through the wrapped pointers.
        for (int i = 0; i < 1024; i++)
            push_rx(8'($urandom_range(0, 255)));
        check("rx_count_full", 32'(dut.rx_count), 32'd1024);
        check("rx_overrun_clear", 32'(rx_overrun), 32'd0);
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        check("rx_overrun_set", 32'(rx_overrun), 32'd1);
        check("rx_count_after_drop", 32'(dut.rx_count), 32'd1024);
        pulse_req();
        for (int i = 0; i < 4; i++)
            push_rx(8'($urandom_range(0, 255)));
        wait_iv(10);
        check("rx_count_push_pop_full", 32'(dut.rx_count), 32'd1024);
        for (int w = 0; w < 256; w++) begin
            pulse_req();
            wait_iv(12);
        end
        check("rx_count_drained", 32'(dut.rx_count), 32'd0);
        check("rx_model_left", 32'(rx_exp_q.size()), 32'd0);
        check("rx_overrun_sticky", 32'(rx_overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
